// File: rtl/viewport_params_seq_if.sv
// Look-at request / viewport-basis result bus for viewport_params_seq.
// The master drives the request side and frame_start; the slave returns the committed basis.
interface viewport_params_seq_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] lookat_x;
    logic signed [DATA_W-1:0] lookat_y;
    logic signed [DATA_W-1:0] lookat_z;
    logic signed [DATA_W-1:0] lookat_h_x;
    logic signed [DATA_W-1:0] lookat_h_y;
    logic                     frame_start;
    logic                     busy;
    logic                     out_valid;
    logic signed [DATA_W-1:0] vp_origin_x;
    logic signed [DATA_W-1:0] vp_origin_y;
    logic signed [DATA_W-1:0] vp_origin_z;
    logic signed [DATA_W-1:0] vp_u_x;
    logic signed [DATA_W-1:0] vp_u_y;
    logic signed [DATA_W-1:0] vp_u_z;
    logic signed [DATA_W-1:0] vp_v_x;
    logic signed [DATA_W-1:0] vp_v_y;
    logic signed [DATA_W-1:0] vp_v_z;

    modport master (
        output in_valid, lookat_x, lookat_y, lookat_z, lookat_h_x, lookat_h_y, frame_start,
        input  in_ready, busy, out_valid,
        input  vp_origin_x, vp_origin_y, vp_origin_z,
        input  vp_u_x, vp_u_y, vp_u_z, vp_v_x, vp_v_y, vp_v_z
    );

    modport slave (
        input  in_valid, lookat_x, lookat_y, lookat_z, lookat_h_x, lookat_h_y, frame_start,
        output in_ready, busy, out_valid,
        output vp_origin_x, vp_origin_y, vp_origin_z,
        output vp_u_x, vp_u_y, vp_u_z, vp_v_x, vp_v_y, vp_v_z
    );
endinterface

// File: rtl/viewport_params_seq.sv
// Multi-cycle viewport basis generator: one vector component per state, results
// double-buffered and optionally committed only on a frame boundary.
module viewport_params_seq #(
    parameter int DATA_W     = 16,
    parameter int H_DISP     = 1280,
    parameter int V_DISP     = 720,
    parameter int SCALE      = 225,
    parameter int FRAME_SYNC = 1
) (
    input logic clk,
    input logic rst,
    viewport_params_seq_if.slave bus
);
    localparam int IW = 2 * DATA_W + 16;
    localparam logic signed [IW-1:0] H_W   = IW'(H_DISP);
    localparam logic signed [IW-1:0] V_W   = IW'(V_DISP);
    localparam logic signed [IW-1:0] S_W   = IW'(SCALE);
    localparam logic signed [IW-1:0] TWO_W = IW'(2);

    typedef enum logic [2:0] {IDLE, VX, VY, VZ, OX, OY, OZ, COMMIT} state_t;

    state_t state, state_next;

    logic signed [DATA_W-1:0] l_x, l_y, l_z, u_x, u_y;
    logic signed [DATA_W-1:0] v_x, v_y, v_z, o_x, o_y, o_z;
    logic signed [DATA_W-1:0] q_o_x, q_o_y, q_o_z, q_u_x, q_u_y, q_v_x, q_v_y, q_v_z;
    logic ready_q, busy_q, out_valid_q;
    logic accept, commit_go;

    logic signed [IW-1:0] wl_x, wl_y, wl_z, wu_x, wu_y, wv_x, wv_y, wv_z;
    logic signed [IW-1:0] v_x_calc, v_y_calc, v_z_calc, o_x_calc, o_y_calc, o_z_calc;

    // /2 then /SCALE as two separate truncating divisions, so odd intermediates round twice.
    function automatic logic signed [IW-1:0] origin_term(input logic signed [IW-1:0] l,
                                                         input logic signed [IW-1:0] u,
                                                         input logic signed [IW-1:0] v);
        logic signed [IW-1:0] half;
        half = (-u * H_W + v * V_W) / TWO_W;
        return (l + half / S_W) * TWO_W;
    endfunction

    always_comb begin
        wl_x = IW'(l_x);
        wl_y = IW'(l_y);
        wl_z = IW'(l_z);
        wu_x = IW'(u_x);
        wu_y = IW'(u_y);
        wv_x = IW'(v_x);
        wv_y = IW'(v_y);
        wv_z = IW'(v_z);
        v_x_calc = (wu_y * wl_z) / S_W;
        v_y_calc = (-wu_x * wl_z) / S_W;
        v_z_calc = (wu_x * wl_y - wu_y * wl_x) / S_W;
        o_x_calc = origin_term(wl_x, wu_x, wv_x);
        o_y_calc = origin_term(wl_y, wu_y, wv_y);
        o_z_calc = origin_term(wl_z, '0, wv_z);
    end

    assign accept    = bus.in_valid && ready_q;
    assign commit_go = (state == COMMIT) && ((FRAME_SYNC == 0) || bus.frame_start);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = VX;
            VX:      state_next = VY;
            VY:      state_next = VZ;
            VZ:      state_next = OX;
            OX:      state_next = OY;
            OY:      state_next = OZ;
            OZ:      state_next = COMMIT;
            COMMIT:  if (commit_go) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            ready_q     <= (state_next == IDLE);
            busy_q      <= (state_next != IDLE);
            out_valid_q <= commit_go;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_x <= '0; l_y <= '0; l_z <= '0; u_x <= '0; u_y <= '0;
            v_x <= '0; v_y <= '0; v_z <= '0; o_x <= '0; o_y <= '0; o_z <= '0;
            q_o_x <= '0; q_o_y <= '0; q_o_z <= '0; q_u_x <= '0; q_u_y <= '0;
            q_v_x <= '0; q_v_y <= '0; q_v_z <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    l_x <= bus.lookat_x;
                    l_y <= bus.lookat_y;
                    l_z <= bus.lookat_z;
                    u_x <= bus.lookat_h_y;
                    u_y <= -bus.lookat_h_x;
                end
                VX: v_x <= v_x_calc[DATA_W-1:0];
                VY: v_y <= v_y_calc[DATA_W-1:0];
                VZ: v_z <= v_z_calc[DATA_W-1:0];
                OX: o_x <= o_x_calc[DATA_W-1:0];
                OY: o_y <= o_y_calc[DATA_W-1:0];
                OZ: o_z <= o_z_calc[DATA_W-1:0];
                COMMIT: if (commit_go) begin
                    q_o_x <= o_x; q_o_y <= o_y; q_o_z <= o_z;
                    q_u_x <= u_x; q_u_y <= u_y;
                    q_v_x <= v_x; q_v_y <= v_y; q_v_z <= v_z;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = ready_q;
    assign bus.busy        = busy_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.vp_origin_x = q_o_x;
    assign bus.vp_origin_y = q_o_y;
    assign bus.vp_origin_z = q_o_z;
    assign bus.vp_u_x      = q_u_x;
    assign bus.vp_u_y      = q_u_y;
    assign bus.vp_u_z      = '0;
    assign bus.vp_v_x      = q_v_x;
    assign bus.vp_v_y      = q_v_y;
    assign bus.vp_v_z      = q_v_z;
endmodule

// File: tb/tb_viewport_params_seq.sv
// Bench for viewport_params_seq: dut0 commits immediately, dut1 waits for frame_start.
// A transaction-level model predicts every output; literal checks pin the model.
module tb_viewport_params_seq;
    localparam int DW = 16;
    localparam int H  = 1280;
    localparam int V  = 720;
    localparam int S  = 225;

    typedef logic [8:0][DW-1:0] res_t;  // o_x,o_y,o_z,u_x,u_y,u_z,v_x,v_y,v_z

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    viewport_params_seq_if #(.DATA_W(DW)) ifa ();
    viewport_params_seq_if #(.DATA_W(DW)) ifb ();

    viewport_params_seq #(.DATA_W(DW), .H_DISP(H), .V_DISP(V), .SCALE(S), .FRAME_SYNC(0))
        dut0 (.clk(clk), .rst(rst), .bus(ifa));
    viewport_params_seq #(.DATA_W(DW), .H_DISP(H), .V_DISP(V), .SCALE(S), .FRAME_SYNC(1))
        dut1 (.clk(clk), .rst(rst), .bus(ifb));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    int ov_cnt_a = 0;
    string fname [9] = '{"o_x", "o_y", "o_z", "u_x", "u_y", "u_z", "v_x", "v_y", "v_z"};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Spec arithmetic with explicit truncate-toward-zero and DATA_W wrap.
    function automatic longint tdiv(input longint a, input longint b);
        longint q;
        q = (a < 0 ? -a : a) / (b < 0 ? -b : b);
        return ((a < 0) != (b < 0)) ? -q : q;
    endfunction

    function automatic longint wrap(input longint x);
        logic signed [DW-1:0] t;
        t = x[DW-1:0];
        return longint'(t);
    endfunction

    function automatic res_t calc(input int lx, input int ly, input int lz, input int hx, input int hy);
        longint l [3];
        longint u [3];
        longint v [3];
        res_t r;
        l[0] = lx; l[1] = ly; l[2] = lz;
        u[0] = wrap(hy); u[1] = wrap(-longint'(hx)); u[2] = 0;
        v[0] = wrap(tdiv(u[1] * l[2], S));
        v[1] = wrap(tdiv(-u[0] * l[2], S));
        v[2] = wrap(tdiv(u[0] * l[1] - u[1] * l[0], S));
        for (int k = 0; k < 3; k++) begin
            r[k]     = DW'(wrap(2 * (l[k] + tdiv(tdiv(-u[k] * H + v[k] * V, 2), S))));
            r[3 + k] = DW'(u[k]);
            r[6 + k] = DW'(v[k]);
        end
        return r;
    endfunction

    function automatic res_t get_act(input int d);
        res_t r;
        if (d == 0) r = {ifa.vp_v_z, ifa.vp_v_y, ifa.vp_v_x, ifa.vp_u_z, ifa.vp_u_y, ifa.vp_u_x,
                         ifa.vp_origin_z, ifa.vp_origin_y, ifa.vp_origin_x};
        else        r = {ifb.vp_v_z, ifb.vp_v_y, ifb.vp_v_x, ifb.vp_u_z, ifb.vp_u_y, ifb.vp_u_x,
                         ifb.vp_origin_z, ifb.vp_origin_y, ifb.vp_origin_x};
        return r;
    endfunction

    // Transaction model: phase counts edges since acceptance, commit from the 7th edge on.
    res_t m_work [2] = '{'0, '0};
    res_t m_out  [2] = '{'0, '0};
    int   m_phase[2] = '{0, 0};
    bit   m_ready[2] = '{0, 0};
    bit   m_ov   [2] = '{0, 0};

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_work[d] = '0; m_out[d] = '0; m_phase[d] = 0; m_ready[d] = 0; m_ov[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic vld, fs;
                res_t cand;
                if (d == 0) begin
                    vld = ifa.in_valid; fs = ifa.frame_start;
                    cand = calc(ifa.lookat_x, ifa.lookat_y, ifa.lookat_z, ifa.lookat_h_x, ifa.lookat_h_y);
                end else begin
                    vld = ifb.in_valid; fs = ifb.frame_start;
                    cand = calc(ifb.lookat_x, ifb.lookat_y, ifb.lookat_z, ifb.lookat_h_x, ifb.lookat_h_y);
                end
                m_ov[d] = 0;
                if (m_phase[d] == 0) begin
                    if (m_ready[d] && vld) begin
                        m_work[d] = cand;
                        m_phase[d] = 1;
                    end
                end else if (m_phase[d] < 7) begin
                    m_phase[d]++;
                end else if (d == 0 || fs) begin
                    m_out[d] = m_work[d];
                    m_ov[d] = 1;
                    m_phase[d] = 0;
                end
                m_ready[d] = (m_phase[d] == 0);
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            res_t act;
            logic rdy, bsy, ov;
            act = get_act(d);
            rdy = (d == 0) ? ifa.in_ready : ifb.in_ready;
            bsy = (d == 0) ? ifa.busy : ifb.busy;
            ov  = (d == 0) ? ifa.out_valid : ifb.out_valid;
            for (int k = 0; k < 9; k++)
                chk($sformatf("dut%0d %s @%0d", d, fname[k], cyc),
                    64'($signed(act[k])), 64'($signed(m_out[d][k])));
            chk($sformatf("dut%0d in_ready @%0d", d, cyc), 64'(rdy), 64'(m_ready[d]));
            chk($sformatf("dut%0d busy @%0d", d, cyc), 64'(bsy), 64'(m_phase[d] != 0));
            chk($sformatf("dut%0d out_valid @%0d", d, cyc), 64'(ov), 64'(m_ov[d]));
        end
        if (ifa.out_valid === 1'b1) ov_cnt_a++;
    end

    task automatic lit(input int d, input string tag, input int ox, input int oy, input int oz,
                       input int ux, input int uy, input int uz, input int vx, input int vy, input int vz);
        res_t act;
        int e [9];
        act = get_act(d);
        e = '{ox, oy, oz, ux, uy, uz, vx, vy, vz};
        for (int k = 0; k < 9; k++)
            chk($sformatf("%s %s", tag, fname[k]), 64'($signed(act[k])), 64'(e[k]));
    endtask

    task automatic drive(input int d, input int lx, input int ly, input int lz, input int hx, input int hy);
        if (d == 0) begin
            ifa.lookat_x = DW'(lx); ifa.lookat_y = DW'(ly); ifa.lookat_z = DW'(lz);
            ifa.lookat_h_x = DW'(hx); ifa.lookat_h_y = DW'(hy);
        end else begin
            ifb.lookat_x = DW'(lx); ifb.lookat_y = DW'(ly); ifb.lookat_z = DW'(lz);
            ifb.lookat_h_x = DW'(hx); ifb.lookat_h_y = DW'(hy);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input int d, input int lx, input int ly, input int lz, input int hx, input int hy);
        int i;
        drive(d, lx, ly, lz, hx, hy);
        if (d == 0) ifa.in_valid = 1'b1; else ifb.in_valid = 1'b1;
        for (i = 0; i < 50; i++) begin
            if (m_ready[d]) break;
            @(negedge clk);
        end
        if (i == 50) begin
            n_chk++; n_fail++;
            $display("FAIL send timeout dut%0d: got not-ready expected ready", d);
        end
        @(negedge clk);
        acc_cyc = cyc;
        if (d == 0) ifa.in_valid = 1'b0; else ifb.in_valid = 1'b0;
    endtask

    task automatic wait_commit_a();
        int i;
        for (i = 0; i < 40; i++) begin
            if (ifa.out_valid === 1'b1) break;
            @(negedge clk);
        end
        if (i == 40) begin
            n_chk++; n_fail++;
            $display("FAIL commit timeout: got no out_valid expected a pulse");
        end else begin
            chk("latency edges after accept", 64'(cyc - acc_cyc), 64'(7));
            chk("in_ready with out_valid", 64'(ifa.in_ready), 64'(1));
        end
    endtask

    task automatic wait_idle(input int d);
        int i;
        for (i = 0; i < 100; i++) begin
            if (m_phase[d] == 0) break;
            @(negedge clk);
        end
        if (i == 100) begin
            n_chk++; n_fail++;
            $display("FAIL idle timeout dut%0d: got busy expected idle", d);
        end
    endtask

    task automatic pulse_fs();
        ifb.frame_start = 1'b1;
        @(negedge clk);
        ifb.frame_start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.in_valid = 0; ifa.frame_start = 0; drive(0, 0, 0, 0, 0, 0);
        ifb.in_valid = 0; ifb.frame_start = 0; drive(1, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        lit(0, "reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("in_ready in reset", 64'(ifa.in_ready), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", 64'(ifa.in_ready), 64'(1));
        chk("busy after reset", 64'(ifa.busy), 64'(0));

        // Immediate-commit vectors with hand-computed results
        send(0, 225, 0, 0, 225, 0);
        wait_commit_a();
        lit(0, "pos", 450, 1280, 720, 0, -225, 0, 0, 0, 225);
        @(negedge clk);
        chk("out_valid one cycle", 64'(ifa.out_valid), 64'(0));
        send(0, -225, 0, 0, -225, 0);
        wait_commit_a();
        lit(0, "neg", -450, -1280, 720, 0, 225, 0, 0, 0, 225);
        @(negedge clk);
        send(0, 0, 0, 1, 225, 0);
        wait_commit_a();
        lit(0, "trunc", -2, 1280, 2, 0, -225, 0, -1, 0, 0);
        @(negedge clk);
        send(0, 100, -50, 200, 30, -170);   wait_idle(0); @(negedge clk);
        send(0, -32000, 17000, 300, 400, -32768); wait_idle(0); @(negedge clk);
        send(0, 7, 7, -7, -3, 5);           wait_idle(0); @(negedge clk);

        // in_valid held high with data changing every cycle
        ov_cnt_a = 0;
        ifa.in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive(0, i * 37 - 500, 300 - i * 11, i * 13 + 1, 225 - i * 9, i * 7 - 100);
            @(negedge clk);
        end
        ifa.in_valid = 1'b0;
        wait_idle(0);
        @(negedge clk);
        chk("stream commit count", 64'(ov_cnt_a), 64'(4));

        // Frame-synchronised commit
        pulse_fs();
        send(1, 225, 0, 0, 225, 0);
        repeat (5) @(negedge clk);
        pulse_fs();   // lands on the edge entering COMMIT, must be ignored
        repeat (3) @(negedge clk);
        chk("fs busy waiting", 64'(ifb.busy), 64'(1));
        chk("fs no early commit", 64'(ifb.out_valid), 64'(0));
        pulse_fs();
        chk("fs commit pulse", 64'(ifb.out_valid), 64'(1));
        lit(1, "fs first", 450, 1280, 720, 0, -225, 0, 0, 0, 225);
        send(1, -225, 0, 0, -225, 0);
        repeat (20) @(negedge clk);
        chk("fs hold busy", 64'(ifb.busy), 64'(1));
        chk("fs hold in_ready", 64'(ifb.in_ready), 64'(0));
        lit(1, "fs hold", 450, 1280, 720, 0, -225, 0, 0, 0, 225);
        pulse_fs();
        chk("fs second pulse", 64'(ifb.out_valid), 64'(1));
        lit(1, "fs second", -450, -1280, 720, 0, 225, 0, 0, 0, 225);
        @(negedge clk);
        chk("fs pulse ends", 64'(ifb.out_valid), 64'(0));
        chk("fs ready again", 64'(ifb.in_ready), 64'(1));

        // Asynchronous reset while dut0 is in OY
        send(0, 100, -50, 200, 30, -170);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        lit(0, "async rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("async rst busy", 64'(ifa.busy), 64'(0));
        chk("async rst dut1 o_x", 64'($signed(ifb.vp_origin_x)), 64'(0));
        #1 rst = 1'b0;
        @(negedge clk);
        send(0, 0, 0, 1, 225, 0);
        wait_commit_a();
        lit(0, "after rst", -2, 1280, 2, 0, -225, 0, -1, 0, 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
